md_stall_ctrl: RTL and testbench

Pipeline stall controller for the five-stage core, extended for the multi-cycle multiply/divide (HI/LO) unit. It tracks the busy window of an in-flight mult/div and merges the resulting structural stall with the data-hazard stall from the hazard unit. It drives the PC write-disable, the IF/ID hold and the ID/EX bubble insertion. It sits beside the hazard unit in the ID stage and sequences the MD unit in EX.

---
 rtl/md_stall_ctrl_pkg.sv | 15 +
 rtl/md_busy_timer.sv | 71 +++++++
 rtl/md_stall_ctrl.sv | 50 +++++
 tb/tb_md_stall_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/md_stall_ctrl_pkg.sv
// Shared definitions for the multiply/divide stall controller and the MD datapath.
package md_stall_ctrl_pkg;

  // MD unit occupancy state
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  // Default occupancy latencies; the MD datapath uses the same values so both agree
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks the busy window of an in-flight mult/div: state, down-counter,
// one-cycle completion pulse and a sticky start-while-busy error flag.
module md_busy_timer
  import md_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             err_q;

  // Occupancy FSM: load latency on start, count down, pulse done on the cycle after the last busy cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            if (is_div_i) begin
              state_q <= MD_DIV;
              cnt_q   <= CNT_W'(DIV_LAT);
            end else begin
              state_q <= MD_MUL;
              cnt_q   <= CNT_W'(MULT_LAT);
            end
          end
        end
        MD_MUL, MD_DIV: begin
          // A start while occupied is dropped; the running operation is left untouched
          if (start_i) begin
            err_q <= 1'b1;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: rtl/md_stall_ctrl.sv
// Pipeline stall controller: merges the hazard-unit data stall with the
// structural stall caused by the multi-cycle multiply/divide unit.
module md_stall_ctrl
  import md_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic Stall_Data,
  input  logic md_use_D,
  input  logic md_start_E,
  input  logic md_is_div_E,
  output logic disable_PC,
  output logic stall_IF_ID,
  output logic flash_ID_EX,
  output logic md_busy,
  output logic md_done,
  output logic md_err
);

  logic stall_md;
  logic stall_all;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start_E),
    .is_div_i (md_is_div_E),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .err_o    (md_err)
  );

  // An MD-using instruction in ID waits while the unit is busy or is being started
  // this very cycle; the start term covers the cycle before busy rises.
  always_comb begin
    stall_md  = md_use_D & (md_busy | md_start_E);
    stall_all = Stall_Data | stall_md;
  end

  assign disable_PC  = stall_all;
  assign stall_IF_ID = stall_all;
  assign flash_ID_EX = stall_all;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Self-checking bench for md_stall_ctrl: timeline model plus directed literal checks.
module tb_md_stall_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset;
  logic Stall_Data;
  logic md_use_D;
  logic md_start_E;
  logic md_is_div_E;
  logic disable_PC;
  logic stall_IF_ID;
  logic flash_ID_EX;
  logic md_busy;
  logic md_done;
  logic md_err;

  int checks   = 0;
  int failures = 0;

  md_stall_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Stall_Data  (Stall_Data),
    .md_use_D    (md_use_D),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .disable_PC  (disable_PC),
    .stall_IF_ID (stall_IF_ID),
    .flash_ID_EX (flash_ID_EX),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_err      (md_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted start in cycle c occupies cycles c+1..c+LAT and
  // signals completion in cycle c+LAT+1.
  int cyc      = 0;
  int busy_end = -1;
  int done_at  = -1;
  bit m_err    = 1'b0;
  bit mvalid   = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      busy_end = -1;
      done_at  = -1;
      m_err    = 1'b0;
    end else if (md_start_E) begin
      if (cyc <= busy_end) begin
        m_err = 1'b1;
      end else begin
        busy_end = cyc + (md_is_div_E ? DIV_LAT : MULT_LAT);
        done_at  = busy_end + 1;
      end
    end
    cyc    = cyc + 1;
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    logic e_busy;
    logic e_stall;
    if (mvalid) begin
      e_busy  = (cyc <= busy_end);
      e_stall = Stall_Data | (md_use_D & (e_busy | md_start_E));
      chk("model_busy", md_busy, e_busy);
      chk("model_done", md_done, (cyc == done_at));
      chk("model_err", md_err, m_err);
      chk("model_disable_PC", disable_PC, e_stall);
      chk("model_stall_IF_ID", stall_IF_ID, e_stall);
      chk("model_flash_ID_EX", flash_ID_EX, e_stall);
    end
  end

  // Apply inputs for one cycle; returns just after mid-cycle so literals can be checked
  task automatic tick(input logic rst_n, input logic sd, input logic use_d,
                      input logic st, input logic dv);
    @(posedge clk);
    #1;
    reset       = rst_n;
    Stall_Data  = sd;
    md_use_D    = use_d;
    md_start_E  = st;
    md_is_div_E = dv;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    Stall_Data  = 1'b0;
    md_use_D    = 1'b0;
    md_start_E  = 1'b0;
    md_is_div_E = 1'b0;

    // Reset: registered outputs clear, stall follows inputs
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_done", md_done, 1'b0);
    chk("rst_err", md_err, 1'b0);
    chk("rst_stall_follows_data", disable_PC, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall_low", flash_ID_EX, 1'b0);

    // Idle data-stall pulse
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dpulse_stall", stall_IF_ID, 1'b1);
    chk("dpulse_busy", md_busy, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dpulse_stall_off", stall_IF_ID, 1'b0);

    // mult with mflo in ID from the start cycle
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mul_t0_stall", disable_PC, 1'b1);
    chk("mul_t0_busy", md_busy, 1'b0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      tick(1'b1, (k == 2), 1'b1, 1'b0, 1'b0);
      chk("mul_busy_win", md_busy, 1'b1);
      chk("mul_stall_win", disable_PC, 1'b1);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mul_done", md_done, 1'b1);
    chk("mul_done_busy", md_busy, 1'b0);
    chk("mul_done_stall", disable_PC, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mul_done_once", md_done, 1'b0);

    // div, no MD use in ID: busy 10 cycles, no stall
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("div_t0_stall", flash_ID_EX, 1'b0);
    for (int k = 1; k <= DIV_LAT; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("div_busy_win", md_busy, 1'b1);
      chk("div_no_stall", flash_ID_EX, 1'b0);
      chk("div_no_early_done", md_done, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("div_done", md_done, 1'b1);
    chk("div_done_busy", md_busy, 1'b0);

    // div aborted by reset in its 4th busy cycle
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_busy_in_rst_cycle", md_busy, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_busy_cleared", md_busy, 1'b0);
    for (int k = 0; k < DIV_LAT; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_no_done", md_done, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_mul_busy", md_busy, 1'b1);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_mul_done", md_done, 1'b1);

    // Back-to-back: new mult accepted in the done cycle
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= MULT_LAT; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b2b_done", md_done, 1'b1);
    chk("b2b_stall_start", disable_PC, 1'b1);
    for (int k = 1; k <= MULT_LAT; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("b2b_busy", md_busy, 1'b1);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_done2", md_done, 1'b1);
    chk("b2b_err_clear", md_err, 1'b0);

    // Start while busy: err sticks, original completes, second ignored
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("err_not_yet", md_err, 1'b0);
    for (int k = 3; k <= MULT_LAT; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("err_set", md_err, 1'b1);
      chk("err_busy", md_busy, 1'b1);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_orig_done", md_done, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_second_dropped", md_busy, 1'b0);
    chk("err_sticky", md_err, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_cleared_by_rst", md_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
